// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: issues word requests to instruction memory,
// hands legal instructions to the decoder, and halts on an illegal opcode.
module ifetch_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        mem_req_I,
   output logic [29:0] mem_addr_I,
   input  logic        mem_ack_I,
   input  logic [31:0] mem_rdata_I,
   input  logic        redirect_valid,
   input  logic [29:0] redirect_addr,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [29:0] inst_pc,
   output logic        halt,
   output logic [15:0] fetch_cnt
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

   state_t      state;
   logic [29:0] pc;
   logic        kill;
   logic [29:0] tgt;

   function automatic logic opcode_legal(input logic [6:0] op);
      logic ok;
      case (op)
         7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
         7'b0100011, 7'b0010011, 7'b0110011: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   // While a killed request is outstanding, pc already holds the redirect target
   always_comb begin
      tgt = redirect_valid ? redirect_addr : pc;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= '0;
         kill       <= 1'b0;
         mem_req_I  <= 1'b0;
         mem_addr_I <= '0;
         inst_valid <= 1'b0;
         inst_data  <= '0;
         inst_pc    <= '0;
         halt       <= 1'b0;
         fetch_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               pc <= tgt;
               if (start) begin
                  state      <= REQ;
                  mem_req_I  <= 1'b1;
                  mem_addr_I <= tgt;
               end
            end
            REQ: begin
               if (mem_ack_I) begin
                  if (kill || redirect_valid) begin
                     kill       <= 1'b0;
                     pc         <= tgt;
                     mem_addr_I <= tgt;
                  end else if (opcode_legal(mem_rdata_I[6:0])) begin
                     inst_data  <= mem_rdata_I;
                     inst_pc    <= mem_addr_I;
                     inst_valid <= 1'b1;
                     pc         <= mem_addr_I + 30'd1;
                     mem_req_I  <= 1'b0;
                     state      <= HOLD;
                  end else begin
                     halt      <= 1'b1;
                     mem_req_I <= 1'b0;
                     state     <= HALT;
                  end
               end else if (redirect_valid) begin
                  kill <= 1'b1;
                  pc   <= redirect_addr;
               end
            end
            HOLD: begin
               if (redirect_valid || inst_ready) begin
                  inst_valid <= 1'b0;
                  pc         <= tgt;
                  mem_req_I  <= 1'b1;
                  mem_addr_I <= tgt;
                  state      <= REQ;
                  if (!redirect_valid)
                     fetch_cnt <= fetch_cnt + 16'd1;
               end
            end
            HALT: ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: ports clk and rst_n; all state changes occur on posedge clk only.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 start  input  1  begin fetching from current PC; honoured only in IDLE.
REQ-005 mem_req_I  output  1  instruction-memory request; held high until mem_ack_I.
REQ-006 mem_addr_I  output  30  word address [31:2]; stable while mem_req_I=1 and not yet acked.
REQ-007 mem_ack_I  input  1  memory completes request; mem_rdata_I valid in the same cycle.
REQ-008 mem_rdata_I  input  32  fetched instruction word.
REQ-009 redirect_valid  input  1  one-cycle pulse: change PC (jump/branch taken).
REQ-010 redirect_addr  input  30  new word address [31:2], sampled with redirect_valid.
REQ-011 inst_valid  output  1  inst_data/inst_pc hold a fetched instruction for the decoder.
REQ-012 inst_ready  input  1  decoder accepts; transfer when inst_valid&inst_ready.
REQ-013 inst_data  output  32  fetched instruction word.
REQ-014 inst_pc  output  30  word address of inst_data.
REQ-015 halt  output  1  illegal opcode fetched; controller stopped.
REQ-016 fetch_cnt  output  16  count of completed inst transfers.

Function
REQ-017 States SHALL be IDLE, REQ, HOLD, HALT; internal pc (30 b) and kill flag (1 b).
REQ-018 IDLE: mem_req_I=0, inst_valid=0; start=1 -> REQ with mem_addr_I=pc, so mem_req_I=1 the cycle after start.
REQ-019 IDLE with redirect_valid: pc<=redirect_addr, stay IDLE; redirect and start together -> REQ at redirect_addr.
REQ-020 REQ: mem_req_I=1, mem_addr_I=pc; mem_addr_I SHALL NOT change before mem_ack_I.
REQ-021 REQ, redirect_valid without ack: kill<=1, pc<=redirect_addr recorded; mem_addr_I keeps the outstanding address (internal target register holds the new PC).
REQ-022 REQ, ack with kill=1 or redirect_valid same cycle: data discarded, kill<=0, stay REQ; next cycle mem_addr_I=redirect target, mem_req_I=1.
REQ-023 REQ, ack, no kill/redirect, opcode mem_rdata_I[6:0] legal: inst_data<=mem_rdata_I, inst_pc<=mem_addr_I, inst_valid<=1, pc<=mem_addr_I+1, -> HOLD (inst_valid high the cycle after ack; mem_req_I=0 in HOLD).
REQ-024 Legal opcodes SHALL be exactly 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011; func3/func7 not checked.
REQ-025 REQ, ack, no kill/redirect, illegal opcode: -> HALT, halt<=1, inst_valid stays 0; illegal opcode in a discarded fetch SHALL be ignored.
REQ-026 HOLD: inst_valid=1, inst_data/inst_pc stable until transfer; inst_valid&inst_ready -> inst_valid<=0, fetch_cnt+=1, -> REQ (mem_req_I high next cycle, addr=pc).
REQ-027 HOLD with redirect_valid: held instruction dropped (no fetch_cnt increment even if inst_ready=1), inst_valid<=0, pc<=redirect_addr, -> REQ.
REQ-028 HALT: halt=1, mem_req_I=0, inst_valid=0; start and redirect ignored; exit only by reset.
REQ-029 pc increment SHALL wrap 30'h3FFFFFFF -> 0; fetch_cnt SHALL wrap 16'hFFFF -> 0.
REQ-030 Minimum throughput: one transfer per 2 cycles (ack cycle + HOLD cycle with inst_ready=1).

Reset
REQ-031 rst_n=0 at posedge clk SHALL force IDLE, pc=0, kill=0, mem_req_I=0, mem_addr_I=0, inst_valid=0, inst_data=0, inst_pc=0, halt=0, fetch_cnt=0, regardless of state or outstanding request.
REQ-032 An ack arriving in the reset cycle SHALL be discarded; after reset no output changes until start.

Verification
REQ-033 Reset, start at cycle 1, ack every REQ cycle with 32'h00000013, inst_ready=1 -> mem_addr_I 0,1,2,...; inst_pc matches; fetch_cnt increments every 2 cycles.
REQ-034 HOLD with inst_ready=0 for 5 cycles -> inst_valid=1, inst_data/inst_pc unchanged, mem_req_I=0; then ready=1 -> transfer, fetch_cnt+1.
REQ-035 REQ at addr 4, redirect_valid to 30'h100 two cycles before ack -> mem_addr_I stays 4 until ack, data dropped, next mem_addr_I=30'h100, no inst_valid for addr 4.
REQ-036 Redirect to 30'h40 in HOLD with inst_ready=1 same cycle -> inst_valid falls, fetch_cnt unchanged, next request at 30'h40.
REQ-037 Ack with mem_rdata_I=32'hFFFFFFFF -> halt=1 next cycle, no further mem_req_I; start/redirect ignored; rst_n=0 -> all outputs 0, IDLE.
REQ-038 Redirect to 30'h3FFFFFFF, fetch and transfer -> next mem_addr_I=0 (wrap).
